// File: rtl/inst_queue_pkg.sv
// Shared definitions for the instruction queue and its dispatch control:
// opcode constants, the stored {inst, pc} record and the head-class helper.
package inst_queue_pkg;

   localparam int DATA_LENGTH = 32;
   localparam int PC_LENGTH   = 32;

   localparam logic [6:0] LOAD_OPCODE  = 7'b0000011;
   localparam logic [6:0] STORE_OPCODE = 7'b0100011;

   typedef struct packed {
      logic [DATA_LENGTH-1:0] inst;
      logic [PC_LENGTH-1:0]   pc;
   } iq_entry_t;

   typedef enum logic [1:0] {
      INST_CLASS_ALU,
      INST_CLASS_LOAD,
      INST_CLASS_STORE
   } inst_class_e;

   // Loads and stores need an LSB slot as well as RS and ROB slots.
   function automatic inst_class_e classify_inst(input logic [6:0] opcode);
      inst_class_e cls;
      case (opcode)
         LOAD_OPCODE:  cls = INST_CLASS_LOAD;
         STORE_OPCODE: cls = INST_CLASS_STORE;
         default:      cls = INST_CLASS_ALU;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/iq_dispatch_ctrl.sv
// Dispatch gating for one candidate instruction: classifies the opcode as
// memory or not and decides whether every consumer it needs has room.
module iq_dispatch_ctrl
   import inst_queue_pkg::*;
(
   input  logic [6:0] candidate_opcode,
   input  logic       has_candidate,
   input  logic       is_ready_from_rs,
   input  logic       is_ready_from_rob,
   input  logic       is_ready_from_lsb,
   output logic       pop_fire
);

   logic is_mem;

   // A candidate dispatches only when RS, ROB and, for memory ops, LSB can all take it.
   always_comb begin
      is_mem   = 1'b0;
      pop_fire = 1'b0;
      if (classify_inst(candidate_opcode) != INST_CLASS_ALU) begin
         is_mem = 1'b1;
      end
      pop_fire = has_candidate && is_ready_from_rs && is_ready_from_rob &&
                 (!is_mem || is_ready_from_lsb);
   end

endmodule

// File: rtl/inst_queue.sv
// Circular instruction FIFO between fetch and decode/dispatch. Buffers
// {inst, pc} pairs and releases one per cycle into a registered dispatch
// slot. A ROB exception flushes everything. Optional macro IQ_BYPASS_EN lets
// an instruction arriving at an empty queue dispatch in its push cycle.
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int IqLength      = 15,
   parameter int PointerLength = 3
)
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     is_valid_from_if,
   input  logic [31:0]              inst_from_if,
   input  logic [31:0]              pc_from_if,
   input  logic                     is_ready_from_rs,
   input  logic                     is_ready_from_rob,
   input  logic                     is_ready_from_lsb,
   input  logic                     is_exception_from_rob,
   output logic                     is_full_to_if,
   output logic [31:0]              inst_to_dc,
   output logic [31:0]              pc_to_dc,
   output logic                     is_empty_to_dc,
   output logic [PointerLength+1:0] count_to_if
);

   localparam logic [PointerLength+1:0] IqDepth  = (PointerLength+2)'(IqLength + 1);
   localparam logic [PointerLength+1:0] CountOne = (PointerLength+2)'(1);
   localparam logic [PointerLength:0]   PtrOne   = (PointerLength+1)'(1);

   iq_entry_t               entries [0:IqLength];
   iq_entry_t               head_entry;
   iq_entry_t               incoming;
   logic [PointerLength:0]   head;
   logic [PointerLength:0]   tail;
   logic [PointerLength+1:0] count;
   logic [PointerLength+1:0] count_next;
   logic                     queue_nonempty;
   logic                     push_acc;
   logic                     store_push;
   logic                     pop_fire;
   logic                     bypass_fire;

   assign is_full_to_if  = (count == IqDepth);
   assign count_to_if    = count;
   assign queue_nonempty = (count != '0);
   assign push_acc       = is_valid_from_if && !is_full_to_if;
   assign head_entry     = entries[head];
   assign incoming       = '{inst: inst_from_if, pc: pc_from_if};
   assign store_push     = push_acc && !bypass_fire;

   iq_dispatch_ctrl u_head_ctrl (
      .candidate_opcode  (head_entry.inst[6:0]),
      .has_candidate     (queue_nonempty),
      .is_ready_from_rs  (is_ready_from_rs),
      .is_ready_from_rob (is_ready_from_rob),
      .is_ready_from_lsb (is_ready_from_lsb),
      .pop_fire          (pop_fire)
   );

`ifdef IQ_BYPASS_EN
   logic bypass_ok;

   iq_dispatch_ctrl u_bypass_ctrl (
      .candidate_opcode  (inst_from_if[6:0]),
      .has_candidate     (push_acc && !queue_nonempty),
      .is_ready_from_rs  (is_ready_from_rs),
      .is_ready_from_rob (is_ready_from_rob),
      .is_ready_from_lsb (is_ready_from_lsb),
      .pop_fire          (bypass_ok)
   );

   assign bypass_fire = bypass_ok;
`else
   assign bypass_fire = 1'b0;
`endif

   // Occupancy moves by one for a stored push or a pop; both together cancel.
   always_comb begin
      count_next = count;
      case ({store_push, pop_fire})
         2'b10:   count_next = count + CountOne;
         2'b01:   count_next = count - CountOne;
         default: count_next = count;
      endcase
   end

   // Entry storage has no reset; contents are only meaningful below count.
   always_ff @(posedge clk) begin
      if (!rst && !is_exception_from_rob && store_push) begin
         entries[tail] <= incoming;
      end
   end

   // Pointers, occupancy and the dispatch slot; reset beats flush beats push/pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         head           <= '0;
         tail           <= '0;
         count          <= '0;
         is_empty_to_dc <= 1'b1;
         inst_to_dc     <= '0;
         pc_to_dc       <= '0;
      end else if (is_exception_from_rob) begin
         head           <= '0;
         tail           <= '0;
         count          <= '0;
         is_empty_to_dc <= 1'b1;
      end else begin
         count <= count_next;
         if (store_push) begin
            tail <= tail + PtrOne;
         end
         if (pop_fire) begin
            inst_to_dc     <= head_entry.inst;
            pc_to_dc       <= head_entry.pc;
            is_empty_to_dc <= 1'b0;
            head           <= head + PtrOne;
         end else if (bypass_fire) begin
            inst_to_dc     <= inst_from_if;
            pc_to_dc       <= pc_from_if;
            is_empty_to_dc <= 1'b0;
         end else begin
            is_empty_to_dc <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: a directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_inst_queue;
   import inst_queue_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        is_valid_from_if = 1'b0;
   logic [31:0] inst_from_if = '0;
   logic [31:0] pc_from_if = '0;
   logic        is_ready_from_rs = 1'b0;
   logic        is_ready_from_rob = 1'b0;
   logic        is_ready_from_lsb = 1'b0;
   logic        is_exception_from_rob = 1'b0;
   logic        is_full_to_if;
   logic [31:0] inst_to_dc;
   logic [31:0] pc_to_dc;
   logic        is_empty_to_dc;
   logic [4:0]  count_to_if;

   int vectorsApplied = 0;
   int miscompares    = 0;
   int droppedPushes  = 0;

   // Reference model: a plain queue of pending entries plus the dispatch slot.
   iq_entry_t   mq[$];
   logic [31:0] mInst = '0;
   logic [31:0] mPc = '0;
   logic        mEmpty = 1'b1;

   typedef struct {
      logic        r;
      logic        v;
      logic [31:0] inst;
      logic [31:0] pc;
      logic        rs;
      logic        rob;
      logic        lsb;
      logic        exc;
      logic        expEmpty;
      logic [31:0] expInst;
      logic [4:0]  expCount;
      logic        expFull;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   inst_queue dut (
      .clk                   (clk),
      .rst                   (rst),
      .is_valid_from_if      (is_valid_from_if),
      .inst_from_if          (inst_from_if),
      .pc_from_if            (pc_from_if),
      .is_ready_from_rs      (is_ready_from_rs),
      .is_ready_from_rob     (is_ready_from_rob),
      .is_ready_from_lsb     (is_ready_from_lsb),
      .is_exception_from_rob (is_exception_from_rob),
      .is_full_to_if         (is_full_to_if),
      .inst_to_dc            (inst_to_dc),
      .pc_to_dc              (pc_to_dc),
      .is_empty_to_dc        (is_empty_to_dc),
      .count_to_if           (count_to_if)
   );

   // Fetch must never push into a full queue; count each time it happens.
   always @(negedge clk) begin
      if (!rst && !is_exception_from_rob && is_valid_from_if && is_full_to_if) begin
         droppedPushes++;
         $display("[TB] note: push while full at %0t is dropped", $time);
      end
   end

   function automatic bit isMemOp(input logic [31:0] w);
      return (w[6:0] == 7'b0000011) || (w[6:0] == 7'b0100011);
   endfunction

   function automatic vec_t mk(input logic r, v, input logic [31:0] inst, pc,
                               input logic rs, rob, lsb, exc, eEmpty,
                               input logic [31:0] eInst, input logic [4:0] eCount,
                               input logic eFull);
      vec_t x;
      x.r = r; x.v = v; x.inst = inst; x.pc = pc;
      x.rs = rs; x.rob = rob; x.lsb = lsb; x.exc = exc;
      x.expEmpty = eEmpty; x.expInst = eInst; x.expCount = eCount; x.expFull = eFull;
      return x;
   endfunction

   task automatic modelStep(input logic r, v, input logic [31:0] inst, pc,
                            input logic rs, rob, lsb, exc);
      bit full;
      bit pushOk;
      bit bypass;
      iq_entry_t e;
      bypass = 1'b0;
`ifdef IQ_BYPASS_EN
      bypass = 1'b1;
`endif
      if (r) begin
         mq.delete();
         mInst = '0;
         mPc = '0;
         mEmpty = 1'b1;
      end else if (exc) begin
         mq.delete();
         mEmpty = 1'b1;
      end else begin
         full   = (mq.size() == 16);
         pushOk = v && !full;
         if (mq.size() > 0 && rs && rob && (!isMemOp(mq[0].inst) || lsb)) begin
            e = mq.pop_front();
            mInst = e.inst;
            mPc = e.pc;
            mEmpty = 1'b0;
            if (pushOk) mq.push_back('{inst: inst, pc: pc});
         end else if (bypass && mq.size() == 0 && pushOk && rs && rob &&
                      (!isMemOp(inst) || lsb)) begin
            mInst = inst;
            mPc = pc;
            mEmpty = 1'b0;
         end else begin
            mEmpty = 1'b1;
            if (pushOk) mq.push_back('{inst: inst, pc: pc});
         end
      end
   endtask

   task automatic applyStimulus(input logic r, v, input logic [31:0] inst, pc,
                                input logic rs, rob, lsb, exc);
      rst = r;
      is_valid_from_if = v;
      inst_from_if = inst;
      pc_from_if = pc;
      is_ready_from_rs = rs;
      is_ready_from_rob = rob;
      is_ready_from_lsb = lsb;
      is_exception_from_rob = exc;
      modelStep(r, v, inst, pc, rs, rob, lsb, exc);
      @(posedge clk);
      #1;
   endtask

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectorsApplied++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkValue({tag, ".empty"}, 32'(is_empty_to_dc), 32'(mEmpty));
      checkValue({tag, ".count"}, 32'(count_to_if), 32'(mq.size()));
      checkValue({tag, ".full"}, 32'(is_full_to_if), 32'(mq.size() == 16));
      checkValue({tag, ".inst"}, inst_to_dc, mInst);
      checkValue({tag, ".pc"}, pc_to_dc, mPc);
   endtask

   initial begin
      logic [31:0] rnd;
      logic [6:0]  op;
      logic        v;

      // Directed table: reset, first-dispatch latency and LSB gating.
      vecs.push_back(mk(1, 0, 32'h0, 32'h0, 0, 0, 0, 0, 1, 32'h0, 5'd0, 0));
`ifdef IQ_BYPASS_EN
      vecs.push_back(mk(0, 1, 32'h00500093, 32'h0, 1, 1, 1, 0, 0, 32'h00500093, 5'd0, 0));
      vecs.push_back(mk(0, 0, 32'h0, 32'h0, 1, 1, 1, 0, 1, 32'h00500093, 5'd0, 0));
`else
      vecs.push_back(mk(0, 1, 32'h00500093, 32'h0, 1, 1, 1, 0, 1, 32'h0, 5'd1, 0));
      vecs.push_back(mk(0, 0, 32'h0, 32'h0, 1, 1, 1, 0, 0, 32'h00500093, 5'd0, 0));
`endif
      vecs.push_back(mk(0, 0, 32'h0, 32'h0, 1, 1, 1, 0, 1, 32'h00500093, 5'd0, 0));
      vecs.push_back(mk(0, 1, 32'h00002083, 32'h4, 1, 1, 0, 0, 1, 32'h00500093, 5'd1, 0));
      vecs.push_back(mk(0, 0, 32'h0, 32'h0, 1, 1, 0, 0, 1, 32'h00500093, 5'd1, 0));
      vecs.push_back(mk(0, 0, 32'h0, 32'h0, 1, 1, 1, 0, 0, 32'h00002083, 5'd0, 0));
`ifdef IQ_BYPASS_EN
      vecs.push_back(mk(0, 1, 32'h00100113, 32'h8, 1, 1, 0, 0, 0, 32'h00100113, 5'd0, 0));
      vecs.push_back(mk(0, 0, 32'h0, 32'h0, 1, 1, 0, 0, 1, 32'h00100113, 5'd0, 0));
`else
      vecs.push_back(mk(0, 1, 32'h00100113, 32'h8, 1, 1, 0, 0, 1, 32'h00002083, 5'd1, 0));
      vecs.push_back(mk(0, 0, 32'h0, 32'h0, 1, 1, 0, 0, 0, 32'h00100113, 5'd0, 0));
`endif

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].r, vecs[i].v, vecs[i].inst, vecs[i].pc,
                       vecs[i].rs, vecs[i].rob, vecs[i].lsb, vecs[i].exc);
         checkValue($sformatf("vec%0d.empty", i), 32'(is_empty_to_dc), 32'(vecs[i].expEmpty));
         checkValue($sformatf("vec%0d.inst", i), inst_to_dc, vecs[i].expInst);
         checkValue($sformatf("vec%0d.count", i), 32'(count_to_if), 32'(vecs[i].expCount));
         checkValue($sformatf("vec%0d.full", i), 32'(is_full_to_if), 32'(vecs[i].expFull));
      end

      // Fill to 16 with RS stalled, try a 17th push, then drain in order; twice for wrap.
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1, {20'h0, 5'(i), 7'b0010011}, 32'(pass * 256 + 4 * i), 0, 1, 1, 0);
            checkOutput("fill");
         end
         checkValue("full.flag", 32'(is_full_to_if), 32'd1);
         checkValue("full.count", 32'(count_to_if), 32'd16);
         if (pass == 0) begin
            applyStimulus(0, 1, 32'h00000013, 32'h40, 0, 1, 1, 0);
            checkValue("drop.count", 32'(count_to_if), 32'd16);
         end
         for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 1, 1, 0);
            checkValue("drain.empty", 32'(is_empty_to_dc), 32'd0);
            checkValue("drain.pc", pc_to_dc, 32'(pass * 256 + 4 * i));
         end
         applyStimulus(0, 0, 0, 0, 1, 1, 1, 0);
         checkValue("drain.done", 32'(is_empty_to_dc), 32'd1);
      end
      checkValue("drop.seen", 32'(droppedPushes), 32'd1);

      // Five held, simultaneous push and pop, then a flush that swallows a push.
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) applyStimulus(0, 1, 32'h00000013, 32'(4 * i), 0, 1, 1, 0);
      applyStimulus(0, 1, 32'h00000013, 32'h14, 1, 1, 1, 0);
      checkValue("pushpop.count", 32'(count_to_if), 32'd5);
      checkValue("pushpop.empty", 32'(is_empty_to_dc), 32'd0);
      applyStimulus(0, 1, 32'hDEADB013, 32'h18, 1, 1, 1, 1);
      checkValue("flush.count", 32'(count_to_if), 32'd0);
      checkValue("flush.empty", 32'(is_empty_to_dc), 32'd1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, 1, 1, 1, 0);
         checkValue("flush.quiet", 32'(is_empty_to_dc), 32'd1);
         checkOutput("flush");
      end

      // Reset in the middle of dispatch, then confirm a fresh push flows through.
      for (int i = 0; i < 10; i++) applyStimulus(0, 1, 32'h00000013, 32'(4 * i), 0, 1, 1, 0);
      applyStimulus(0, 0, 0, 0, 1, 1, 1, 0);
      checkValue("mid.count", 32'(count_to_if), 32'd9);
      applyStimulus(1, 1, 32'h00000013, 32'h80, 1, 1, 1, 0);
      checkValue("rst.empty", 32'(is_empty_to_dc), 32'd1);
      checkValue("rst.inst", inst_to_dc, 32'h0);
      checkValue("rst.pc", pc_to_dc, 32'h0);
      checkValue("rst.count", 32'(count_to_if), 32'd0);
      checkValue("rst.full", 32'(is_full_to_if), 32'd0);
      applyStimulus(0, 1, 32'h00700193, 32'h200, 1, 1, 1, 0);
      applyStimulus(0, 0, 0, 0, 1, 1, 1, 0);
      checkValue("rst.next.inst", inst_to_dc, 32'h00700193);
      checkValue("rst.next.pc", pc_to_dc, 32'h200);

      // Randomized traffic; fetch honours the full flag, readies and flushes vary.
      for (int i = 0; i < 600; i++) begin
         rnd = $urandom;
         case ($urandom_range(0, 2))
            0:       op = 7'b0000011;
            1:       op = 7'b0100011;
            default: op = 7'b0010011;
         endcase
         v = ($urandom_range(0, 3) != 0) && (mq.size() != 16);
         applyStimulus(($urandom_range(0, 79) == 0), v, {rnd[31:7], op}, $urandom,
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 1) != 0), ($urandom_range(0, 39) == 0));
         checkOutput("rand");
      end
      checkValue("drop.final", 32'(droppedPushes), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

endmodule
